// File: rtl/axi_pkg.sv
// Shared AXI bridge definitions: bus widths, response codes, R-path slave
// indices and router states.
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SLV_S0 = 2'd0,
    SLV_S1 = 2'd1,
    SLV_DS = 2'd2
  } slave_idx_e;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_LOCKED = 1'b1
  } rstate_e;

  // Successor of a slave index in the S0 -> S1 -> DS ring.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-requester picker. With AXI_RDATA_RR_EN defined it searches from ptr
// (round robin); otherwise fixed priority S0 > S1 > DS and no pointer port.
module rr_arbiter3
  import axi_pkg::*;
(
`ifdef AXI_RDATA_RR_EN
  input  logic [1:0] ptr,
`endif
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

`ifdef AXI_RDATA_RR_EN
  logic       found;
  logic [2:0] pos;
  logic [1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = 2'd0;
    found = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int k = 0; k < 3; k++) begin
      pos = {1'b0, ptr} + 3'(k);
      if (pos >= 3'd3) pos = pos - 3'd3;
      cand = pos[1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
`else
  always_comb begin
    gnt = '0;
    idx = SLV_S0;
    if (req[0]) begin
      gnt[0] = 1'b1;
      idx    = SLV_S0;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
      idx    = SLV_S1;
    end else if (req[2]) begin
      gnt[2] = 1'b1;
      idx    = SLV_DS;
    end
  end
`endif

endmodule

// File: rtl/axi_rdata_router.sv
// R-channel return router: S0/S1/DS beats to M0/M1 by upper RID bits, burst-locked
// grants. AXI_RDATA_RR_EN selects round-robin arbitration (default: fixed priority).
//   state    | meaning
//   R_IDLE   | winner forwarded combinationally; lock unless a last beat completes
//   R_LOCKED | only lock_idx forwarded until its RLAST handshake
module axi_rdata_router
  import axi_pkg::*;
#(
  parameter int ID_W   = AXI_ID_BITS,
  parameter int SID_W  = AXI_IDS_BITS,
  parameter int DATA_W = AXI_DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [SID_W-1:0]  S0_RID,
  input  logic [DATA_W-1:0] S0_RData,
  input  logic [1:0]        S0_RResp,
  input  logic              S0_RLast,
  input  logic              S0_RValid,
  output logic              S0_RReady,

  input  logic [SID_W-1:0]  S1_RID,
  input  logic [DATA_W-1:0] S1_RData,
  input  logic [1:0]        S1_RResp,
  input  logic              S1_RLast,
  input  logic              S1_RValid,
  output logic              S1_RReady,

  input  logic [SID_W-1:0]  DS_RID,
  input  logic [DATA_W-1:0] DS_RData,
  input  logic [1:0]        DS_RResp,
  input  logic              DS_RLast,
  input  logic              DS_RValid,
  output logic              DS_RReady,

  output logic [ID_W-1:0]   M0_RID,
  output logic [DATA_W-1:0] M0_RData,
  output logic [1:0]        M0_RResp,
  output logic              M0_RLast,
  output logic              M0_RValid,
  input  logic              M0_RReady,

  output logic [ID_W-1:0]   M1_RID,
  output logic [DATA_W-1:0] M1_RData,
  output logic [1:0]        M1_RResp,
  output logic              M1_RLast,
  output logic              M1_RValid,
  input  logic              M1_RReady
);

  localparam int SEL_W = SID_W - ID_W;

  rstate_e     state;
  logic [1:0]  lock_idx;
`ifdef AXI_RDATA_RR_EN
  logic [1:0]  rr_ptr;
`endif

  logic [2:0]        req;
  logic [2:0]        win_gnt;
  logic [1:0]        win_idx;
  logic [2:0]        lock_oh;
  logic [2:0]        grant_oh;
  logic [1:0]        grant_idx;
  logic              locked;
  logic              active;
  logic [SID_W-1:0]  g_id;
  logic [DATA_W-1:0] g_data;
  logic [1:0]        g_resp;
  logic              g_last;
  logic              g_valid;
  logic [SEL_W-1:0]  g_sel;
  logic              to_m0;
  logic              to_m1;
  logic              g_ready;
  logic              hs_last;

  assign req = {DS_RValid, S1_RValid, S0_RValid};

  rr_arbiter3 u_arb (
`ifdef AXI_RDATA_RR_EN
    .ptr (rr_ptr),
`endif
    .req (req),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  always_comb begin
    lock_oh = '0;
    case (lock_idx)
      SLV_S1:  lock_oh[1] = 1'b1;
      SLV_DS:  lock_oh[2] = 1'b1;
      default: lock_oh[0] = 1'b1;
    endcase
  end

  assign locked    = (state == R_LOCKED);
  assign grant_oh  = locked ? lock_oh : win_gnt;
  assign grant_idx = locked ? lock_idx : win_idx;
  assign active    = |grant_oh;

  always_comb begin
    g_id    = DS_RID;
    g_data  = DS_RData;
    g_resp  = DS_RResp;
    g_last  = DS_RLast;
    g_valid = DS_RValid;
    case (grant_idx)
      SLV_S0: begin
        g_id    = S0_RID;
        g_data  = S0_RData;
        g_resp  = S0_RResp;
        g_last  = S0_RLast;
        g_valid = S0_RValid;
      end
      SLV_S1: begin
        g_id    = S1_RID;
        g_data  = S1_RData;
        g_resp  = S1_RResp;
        g_last  = S1_RLast;
        g_valid = S1_RValid;
      end
      default: ;
    endcase
  end

  // Selects other than 0/1 have no master; the beat is sunk unconditionally.
  assign g_sel   = g_id[SID_W-1:ID_W];
  assign to_m0   = active && (g_sel == SEL_W'(0));
  assign to_m1   = active && (g_sel == SEL_W'(1));
  assign g_ready = to_m0 ? M0_RReady : (to_m1 ? M1_RReady : 1'b1);
  assign hs_last = active && g_valid && g_ready && g_last;

  assign S0_RReady = !rst && grant_oh[0] && g_ready;
  assign S1_RReady = !rst && grant_oh[1] && g_ready;
  assign DS_RReady = !rst && grant_oh[2] && g_ready;

  assign M0_RValid = !rst && to_m0 && g_valid;
  assign M0_RID    = (!rst && to_m0) ? g_id[ID_W-1:0] : '0;
  assign M0_RData  = (!rst && to_m0) ? g_data : '0;
  assign M0_RResp  = (!rst && to_m0) ? g_resp : '0;
  assign M0_RLast  = !rst && to_m0 && g_last;

  assign M1_RValid = !rst && to_m1 && g_valid;
  assign M1_RID    = (!rst && to_m1) ? g_id[ID_W-1:0] : '0;
  assign M1_RData  = (!rst && to_m1) ? g_data : '0;
  assign M1_RResp  = (!rst && to_m1) ? g_resp : '0;
  assign M1_RLast  = !rst && to_m1 && g_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= R_IDLE;
      lock_idx <= 2'd0;
`ifdef AXI_RDATA_RR_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      unique case (state)
        R_IDLE: begin
          // Locking on a stalled first beat keeps master VALID/payload stable.
          if (active && !hs_last) begin
            state    <= R_LOCKED;
            lock_idx <= win_idx;
          end
`ifdef AXI_RDATA_RR_EN
          else if (hs_last) begin
            rr_ptr <= next_idx(win_idx);
          end
`endif
        end
        R_LOCKED: begin
          if (hs_last) begin
            state  <= R_IDLE;
`ifdef AXI_RDATA_RR_EN
            rr_ptr <= next_idx(lock_idx);
`endif
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rdata_router.sv
// Directed bench for axi_rdata_router: slave beat queues drive the DUT and
// per-master expected queues are popped on every master handshake.
module tb_axi_rdata_router;
  import axi_pkg::*;

  typedef struct packed {
    logic [7:0]  sid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } sbeat_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } mbeat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_rid   [3];
  logic [31:0] s_data  [3];
  logic [1:0]  s_resp  [3];
  logic        s_last  [3];
  logic        s_valid [3];
  logic        s_ready [3];

  logic [3:0]  M0_RID, M1_RID;
  logic [31:0] M0_RData, M1_RData;
  logic [1:0]  M0_RResp, M1_RResp;
  logic        M0_RLast, M1_RLast, M0_RValid, M1_RValid;
  logic        M0_RReady, M1_RReady;

  sbeat_t slv_q [3][$];
  mbeat_t q0[$];
  mbeat_t q1[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_rdata_router dut (
    .clk(clk), .rst(rst),
    .S0_RID(s_rid[0]), .S0_RData(s_data[0]), .S0_RResp(s_resp[0]),
    .S0_RLast(s_last[0]), .S0_RValid(s_valid[0]), .S0_RReady(s_ready[0]),
    .S1_RID(s_rid[1]), .S1_RData(s_data[1]), .S1_RResp(s_resp[1]),
    .S1_RLast(s_last[1]), .S1_RValid(s_valid[1]), .S1_RReady(s_ready[1]),
    .DS_RID(s_rid[2]), .DS_RData(s_data[2]), .DS_RResp(s_resp[2]),
    .DS_RLast(s_last[2]), .DS_RValid(s_valid[2]), .DS_RReady(s_ready[2]),
    .M0_RID(M0_RID), .M0_RData(M0_RData), .M0_RResp(M0_RResp),
    .M0_RLast(M0_RLast), .M0_RValid(M0_RValid), .M0_RReady(M0_RReady),
    .M1_RID(M1_RID), .M1_RData(M1_RData), .M1_RResp(M1_RResp),
    .M1_RLast(M1_RLast), .M1_RValid(M1_RValid), .M1_RReady(M1_RReady)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue a slave beat; its routed image goes to the target master's queue.
  task automatic send(input int s, input logic [7:0] sid, input logic [31:0] d,
                      input logic [1:0] r, input logic l);
    sbeat_t b;
    mbeat_t m;
    b = '{sid, d, r, l};
    m = '{sid[3:0], d, r, l};
    slv_q[s].push_back(b);
    if (sid[7:4] == 4'd0) q0.push_back(m);
    else if (sid[7:4] == 4'd1) q1.push_back(m);
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (slv_q[i].size() > 0) begin
        s_valid[i] = 1'b1;
        s_rid[i]   = slv_q[i][0].sid;
        s_data[i]  = slv_q[i][0].data;
        s_resp[i]  = slv_q[i][0].resp;
        s_last[i]  = slv_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
        s_rid[i]   = '0;
        s_data[i]  = '0;
        s_resp[i]  = '0;
        s_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic mon();
    mbeat_t e;
    if (M0_RValid && M0_RReady) begin
      if (q0.size() == 0) check("m0_unexpected_beat", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        check("m0_beat", 64'({M0_RID, M0_RData, M0_RResp, M0_RLast}), 64'(e));
      end
    end
    if (M1_RValid && M1_RReady) begin
      if (q1.size() == 0) check("m1_unexpected_beat", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        check("m1_beat", 64'({M1_RID, M1_RData, M1_RResp, M1_RLast}), 64'(e));
      end
    end
    for (int i = 0; i < 3; i++)
      if (s_valid[i] && s_ready[i] && slv_q[i].size() > 0) void'(slv_q[i].pop_front());
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    mon();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic cycle();
    to_neg();
    finish_cycle();
  endtask

  function automatic int pending();
    return slv_q[0].size() + slv_q[1].size() + slv_q[2].size() + q0.size() + q1.size();
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (pending() > 0 && n < 40) begin
      cycle();
      n++;
    end
    check({tag, "_drain"}, 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) slv_q[i].delete();
    q0.delete();
    q1.delete();
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    drive();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m0"}, 64'({M0_RValid, M0_RID, M0_RData, M0_RResp, M0_RLast}), 64'd0);
    check({tag, "_m1_rdy"}, 64'({M1_RValid, M1_RID, M1_RData, M1_RResp, M1_RLast,
                                 s_ready[0], s_ready[1], s_ready[2]}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    M0_RReady = 1'b1;
    M1_RReady = 1'b1;

    // Outputs stay zero in reset even with a slave presenting a beat.
    send(0, 8'h02, 32'hDEAD_0001, RESP_OKAY, 1'b1);
    drive();
    @(posedge clk);
    #1;
    to_neg();
    check_all_zero("reset_outs");
    finish_cycle();
    check("reset_state", 64'(dut.state), 64'(R_IDLE));
    do_reset();

    // Single beat from S1 to M1, zero latency.
    send(1, 8'h13, 32'h1111_0001, RESP_OKAY, 1'b1);
    drive();
    to_neg();
    check("t1_m1_valid", 64'(M1_RValid), 64'd1);
    check("t1_m1_rid", 64'(M1_RID), 64'h3);
    check("t1_s1_ready", 64'(s_ready[1]), 64'd1);
    check("t1_m0_valid", 64'(M0_RValid), 64'd0);
    finish_cycle();
    check("t1_state_idle", 64'(dut.state), 64'(R_IDLE));
    drain("t1");

    // 4-beat S0 burst with a 3-cycle stall on beat 2; S1 must wait.
    do_reset();
    for (int b = 0; b < 4; b++)
      send(0, 8'h02, 32'h2000_0000 + 32'(b), RESP_OKAY, b == 3);
    send(1, 8'h14, 32'h2222_0001, RESP_SLVERR, 1'b1);
    drive();
    to_neg();
    check("t2_s0_ready", 64'(s_ready[0]), 64'd1);
    check("t2_s1_ready_b1", 64'(s_ready[1]), 64'd0);
    finish_cycle();
    M0_RReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check("t2_stall_valid", 64'(M0_RValid), 64'd1);
      check("t2_stall_data", 64'(M0_RData), 64'h2000_0001);
      check("t2_stall_s1_ready", 64'(s_ready[1]), 64'd0);
      check("t2_stall_m1_valid", 64'(M1_RValid), 64'd0);
      finish_cycle();
    end
    M0_RReady = 1'b1;
    for (int n = 0; n < 20 && pending() > 0; n++) begin
      to_neg();
      if (slv_q[0].size() > 0) check("t2_s1_blocked", 64'(s_ready[1]), 64'd0);
      finish_cycle();
    end
    check("t2_drain", 64'(pending()), 64'd0);

    // Three single-beat requesters, two rounds each, all to M0.
    do_reset();
`ifdef AXI_RDATA_RR_EN
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++)
        send(s, 8'h01, 32'h3000_0000 + 32'(s * 16 + r), RESP_OKAY, 1'b1);
`else
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < 2; r++)
        send(s, 8'h01, 32'h3000_0000 + 32'(s * 16 + r), RESP_OKAY, 1'b1);
`endif
    drive();
    drain("t3_arb");

    // Default slave decode error to M1.
    send(2, 8'h15, 32'h4444_0005, RESP_DECERR, 1'b1);
    drive();
    to_neg();
    check("t4_m1_valid", 64'(M1_RValid), 64'd1);
    check("t4_m1_resp", 64'(M1_RResp), 64'h3);
    check("t4_m1_rid", 64'(M1_RID), 64'h5);
    finish_cycle();
    drain("t4");

    // Bad master select is sunk without any master valid.
    send(1, 8'h70, 32'h5555_0000, RESP_OKAY, 1'b1);
    drive();
    to_neg();
    check("t5_s1_ready", 64'(s_ready[1]), 64'd1);
    check("t5_m0_valid", 64'(M0_RValid), 64'd0);
    check("t5_m1_valid", 64'(M1_RValid), 64'd0);
    finish_cycle();
    check("t5_sunk", 64'(slv_q[1].size()), 64'd0);
    check("t5_state_idle", 64'(dut.state), 64'(R_IDLE));

    // Reset during beat 2 of a 4-beat burst, then a fresh S1 burst.
    do_reset();
    for (int b = 0; b < 4; b++)
      send(0, 8'h02, 32'h6000_0000 + 32'(b), RESP_OKAY, b == 3);
    drive();
    cycle();
    check("t6_locked", 64'(dut.state), 64'(R_LOCKED));
    rst = 1'b1;
    to_neg();
    check_all_zero("t6_rst_outs");
    finish_cycle();
    check("t6_state", 64'(dut.state), 64'(R_IDLE));
    check("t6_lock_idx", 64'(dut.lock_idx), 64'd0);
`ifdef AXI_RDATA_RR_EN
    check("t6_rr_ptr", 64'(dut.rr_ptr), 64'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) slv_q[i].delete();
    q0.delete();
    q1.delete();
    drive();
    to_neg();
    check_all_zero("t6_idle_outs");
    finish_cycle();
    send(1, 8'h16, 32'h7000_0000, RESP_OKAY, 1'b0);
    send(1, 8'h16, 32'h7000_0001, RESP_OKAY, 1'b1);
    drive();
    to_neg();
    check("t6_m1_valid", 64'(M1_RValid), 64'd1);
    finish_cycle();
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
